mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM→WB pipeline register plus write-back state owner; the final integer pipeline stage.
- Latches MEM-stage results each cycle and drives the general register file write port (we/waddr/wdata).
- Owns the architectural HI/LO pair and the LL (load-linked) bit, with same-cycle bypass on their read outputs.
- Honours the pipeline stall vector and exception flush.

Parameters:
- DATA_W, 32, data width of GPR/HI/LO values.
- ADDR_W, 5, GPR address width (32 registers).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  6  pipeline stall vector; bit4 = MEM stalled, bit5 = WB stalled.
- flush  in  1  exception flush; kills the instruction entering WB.
- mem_wd  in  ADDR_W  MEM-stage destination GPR.
- mem_wreg  in  1  MEM-stage GPR write enable.
- mem_wdata  in  DATA_W  MEM-stage GPR write data.
- mem_whilo  in  1  MEM-stage HI/LO write enable.
- mem_hi  in  DATA_W  MEM-stage HI value.
- mem_lo  in  DATA_W  MEM-stage LO value.
- mem_llbit_we  in  1  MEM-stage LL-bit write enable.
- mem_llbit_value  in  1  MEM-stage LL-bit value.
- wb_wd  out  ADDR_W  to register file waddr.
- wb_wreg  out  1  to register file we.
- wb_wdata  out  DATA_W  to register file wdata.
- hi_o  out  DATA_W  current HI, bypassed.
- lo_o  out  DATA_W  current LO, bypassed.
- llbit_o  out  1  current LL bit, bypassed.

Behaviour:

Reset
- rst=1 asynchronously clears all of the following to 0: pipeline register (wb_wd, wb_wreg, wb_wdata, internal whilo/hi/lo/llbit_we/llbit_value), HI, LO, LLbit.
- Consequently every output reads 0 during reset.
- Reset mid-operation discards the in-flight WB instruction; nothing is written on the edge where rst deasserts.

Pipeline register update, per rising edge, in priority order:
1. flush=1: load bubble (all fields 0).
2. stall[4]=1 and stall[5]=0: load bubble.
3. stall[4]=0: capture all mem_* inputs.
4. Otherwise (stall[4]=1 and stall[5]=1): hold.

Pipeline register rules
- Flush wins over any stall combination.
- Latency: mem_* to wb_* is exactly 1 cycle; wb_* outputs are direct register outputs (no combinational path from mem_*).
- wb_wreg is passed as captured, including when wb_wd=0; the register file suppresses writes to r0.

HI/LO
- On a rising edge with registered whilo=1: HI<=hi, LO<=lo.
- hi_o/lo_o = registered hi/lo when registered whilo=1, otherwise the stored HI/LO.
- The bypass makes the committing value visible in the same cycle.
- Stalls do not block the HI/LO commit of the instruction already in WB.
- Because a held WB instruction keeps registered whilo=1, it rewrites the same value on each held cycle; this is idempotent.

LLbit
- On a rising edge with flush=1: LLbit<=0 (an exception breaks the link).
- Otherwise, with registered llbit_we=1: LLbit<=registered llbit_value.
- llbit_o = 0 when flush=1; else registered llbit_value when registered llbit_we=1; else stored LLbit.

Boundaries
- Simultaneous flush and stall: flush behaviour.
- Back-to-back HI/LO writes: each commits in order with no lost update.
- Widths are fixed; no arithmetic is performed.

Optional Feature:
- Macro: MEM_WB_LLBIT_EN.
- Defined: the LLbit register, llbit_we/llbit_value pipeline fields, and the flush clear of LLbit are implemented exactly as above.
- Undefined: no LLbit state is built; mem_llbit_we and mem_llbit_value are ignored; llbit_o is tied to 0.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with wb_wreg=1 → all outputs 0 immediately, without waiting for a clock edge; no register write occurs after release.
- Capture: mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF, stall=0 → next edge gives wb_wd=5, wb_wreg=1, wb_wdata=0xDEADBEEF.
- Stall:
  - stall=6'b010000 → next edge gives wb_wreg=0 (bubble).
  - stall=6'b110000 → wb_* hold their previous values.
- Flush: flush=1 with stall=6'b110000 and wb holding wreg=1 → next edge gives wb_wreg=0; with MEM_WB_LLBIT_EN defined, llbit_o=0 in the flush cycle and LLbit=0 afterwards.
- HI/LO:
  - mem_whilo=1, mem_hi=0x1, mem_lo=0x2 → one cycle later hi_o=0x1, lo_o=0x2 via bypass; the cycle after that, the same values come from stored HI/LO.
  - A following write of 0x3/0x4 is also seen in order.
- LLbit: mem_llbit_we=1, mem_llbit_value=1 → llbit_o=1 one cycle later and stays 1 until a flush or a write of 0; with the macro undefined, llbit_o stays 0 throughout.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and write-back state owner (HI/LO, LL bit).
// Optional LL-bit support is built only when MEM_WB_LLBIT_EN is defined.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_llbit_we,
    input  logic              mem_llbit_value,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              llbit_o
);

    logic              bubble_s;
    logic              capture_s;
    logic              whilo_r;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic [DATA_W-1:0] hi_arch_r;
    logic [DATA_W-1:0] lo_arch_r;
    logic              unused_stall_s;

    // Flush beats every stall; a stalled MEM feeding a running WB inserts a bubble.
    assign bubble_s       = flush | (stall[4] & ~stall[5]);
    assign capture_s      = ~stall[4];
    assign unused_stall_s = ^stall[3:0];

    // Pipeline register for the GPR write port and pending HI/LO write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wd    <= {ADDR_W{1'b0}};
            wb_wreg  <= 1'b0;
            wb_wdata <= {DATA_W{1'b0}};
            whilo_r  <= 1'b0;
            hi_r     <= {DATA_W{1'b0}};
            lo_r     <= {DATA_W{1'b0}};
        end else if (bubble_s) begin
            wb_wd    <= {ADDR_W{1'b0}};
            wb_wreg  <= 1'b0;
            wb_wdata <= {DATA_W{1'b0}};
            whilo_r  <= 1'b0;
            hi_r     <= {DATA_W{1'b0}};
            lo_r     <= {DATA_W{1'b0}};
        end else if (capture_s) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
            whilo_r  <= mem_whilo;
            hi_r     <= mem_hi;
            lo_r     <= mem_lo;
        end
    end

    // Architectural HI/LO; a held instruction rewrites the same value harmlessly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_arch_r <= {DATA_W{1'b0}};
            lo_arch_r <= {DATA_W{1'b0}};
        end else if (whilo_r) begin
            hi_arch_r <= hi_r;
            lo_arch_r <= lo_r;
        end
    end

    // HI/LO read bypass so the committing value is visible this cycle.
    always_comb begin
        hi_o = hi_arch_r;
        lo_o = lo_arch_r;
        if (whilo_r) begin
            hi_o = hi_r;
            lo_o = lo_r;
        end else begin
            hi_o = hi_arch_r;
            lo_o = lo_arch_r;
        end
    end

`ifdef MEM_WB_LLBIT_EN
    logic llbit_we_r;
    logic llbit_value_r;
    logic llbit_r;

    // LL-bit pipeline fields, same update rules as the main pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llbit_we_r    <= 1'b0;
            llbit_value_r <= 1'b0;
        end else if (bubble_s) begin
            llbit_we_r    <= 1'b0;
            llbit_value_r <= 1'b0;
        end else if (capture_s) begin
            llbit_we_r    <= mem_llbit_we;
            llbit_value_r <= mem_llbit_value;
        end
    end

    // An exception breaks the link before any pending LL write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llbit_r <= 1'b0;
        end else if (flush) begin
            llbit_r <= 1'b0;
        end else if (llbit_we_r) begin
            llbit_r <= llbit_value_r;
        end
    end

    // LL-bit read bypass.
    always_comb begin
        llbit_o = llbit_r;
        if (flush) begin
            llbit_o = 1'b0;
        end else if (llbit_we_r) begin
            llbit_o = llbit_value_r;
        end else begin
            llbit_o = llbit_r;
        end
    end
`else
    logic unused_llbit_s;

    assign unused_llbit_s = mem_llbit_we ^ mem_llbit_value;
    assign llbit_o        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; LL-bit expectations follow MEM_WB_LLBIT_EN.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_llbit_we;
    logic        mem_llbit_value;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        llbit_o;

    int errors = 0;
    int checks = 0;

`ifdef MEM_WB_LLBIT_EN
    localparam logic LL_ON = 1'b1;
`else
    localparam logic LL_ON = 1'b0;
`endif

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .hi_o(hi_o), .lo_o(lo_o), .llbit_o(llbit_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        checks++; if (wb_wd !== 5'd0) begin errors++; $display("FAIL %s wb_wd got=%0h exp=0", tag, wb_wd); end
        checks++; if (wb_wreg !== 1'b0) begin errors++; $display("FAIL %s wb_wreg got=%0b exp=0", tag, wb_wreg); end
        checks++; if (wb_wdata !== 32'd0) begin errors++; $display("FAIL %s wb_wdata got=%0h exp=0", tag, wb_wdata); end
        checks++; if (hi_o !== 32'd0) begin errors++; $display("FAIL %s hi_o got=%0h exp=0", tag, hi_o); end
        checks++; if (lo_o !== 32'd0) begin errors++; $display("FAIL %s lo_o got=%0h exp=0", tag, lo_o); end
        checks++; if (llbit_o !== 1'b0) begin errors++; $display("FAIL %s llbit_o got=%0b exp=0", tag, llbit_o); end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 6'd0; flush = 1'b0;
        mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
        mem_whilo = 1'b0; mem_hi = 32'd0; mem_lo = 32'd0;
        mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
        #2;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_capture();
        mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'hDEADBEEF; stall = 6'd0;
        step();
        checks++; if (wb_wd !== 5'd5) begin errors++; $display("FAIL capture_wd got=%0d exp=5", wb_wd); end
        checks++; if (wb_wreg !== 1'b1) begin errors++; $display("FAIL capture_wreg got=%0b exp=1", wb_wreg); end
        checks++; if (wb_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL capture_wdata got=%0h exp=deadbeef", wb_wdata); end
    endtask

    task automatic test_stall();
        mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h12345678; stall = 6'b110000;
        step();
        checks++; if (wb_wd !== 5'd5) begin errors++; $display("FAIL hold_wd got=%0d exp=5", wb_wd); end
        checks++; if (wb_wreg !== 1'b1) begin errors++; $display("FAIL hold_wreg got=%0b exp=1", wb_wreg); end
        checks++; if (wb_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_wdata got=%0h exp=deadbeef", wb_wdata); end
        stall = 6'b010000;
        step();
        checks++; if (wb_wd !== 5'd0) begin errors++; $display("FAIL bubble_wd got=%0d exp=0", wb_wd); end
        checks++; if (wb_wreg !== 1'b0) begin errors++; $display("FAIL bubble_wreg got=%0b exp=0", wb_wreg); end
        checks++; if (wb_wdata !== 32'd0) begin errors++; $display("FAIL bubble_wdata got=%0h exp=0", wb_wdata); end
        stall = 6'd0;
        step();
        checks++; if (wb_wdata !== 32'h12345678) begin errors++; $display("FAIL resume_wdata got=%0h exp=12345678", wb_wdata); end
    endtask

    task automatic test_llbit();
        mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
        step();
        checks++; if (llbit_o !== LL_ON) begin errors++; $display("FAIL ll_bypass got=%0b exp=%0b", llbit_o, LL_ON); end
        mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
        step();
        step();
        checks++; if (llbit_o !== LL_ON) begin errors++; $display("FAIL ll_stored got=%0b exp=%0b", llbit_o, LL_ON); end
    endtask

    task automatic test_flush();
        checks++; if (wb_wreg !== 1'b1) begin errors++; $display("FAIL preflush_wreg got=%0b exp=1", wb_wreg); end
        stall = 6'b110000; flush = 1'b1;
        #1;
        checks++; if (llbit_o !== 1'b0) begin errors++; $display("FAIL flush_ll_same got=%0b exp=0", llbit_o); end
        step();
        checks++; if (wb_wreg !== 1'b0) begin errors++; $display("FAIL flush_wreg got=%0b exp=0", wb_wreg); end
        flush = 1'b0; stall = 6'd0;
        #1;
        checks++; if (llbit_o !== 1'b0) begin errors++; $display("FAIL flush_ll_after got=%0b exp=0", llbit_o); end
        mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
        step();
        checks++; if (llbit_o !== LL_ON) begin errors++; $display("FAIL ll_reset1 got=%0b exp=%0b", llbit_o, LL_ON); end
        mem_llbit_value = 1'b0;
        step();
        mem_llbit_we = 1'b0;
        step();
        checks++; if (llbit_o !== 1'b0) begin errors++; $display("FAIL ll_write0 got=%0b exp=0", llbit_o); end
    endtask

    task automatic test_hilo();
        mem_whilo = 1'b1; mem_hi = 32'h1; mem_lo = 32'h2;
        step();
        checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL hi_bypass got=%0h exp=1", hi_o); end
        checks++; if (lo_o !== 32'h2) begin errors++; $display("FAIL lo_bypass got=%0h exp=2", lo_o); end
        mem_whilo = 1'b0; mem_hi = 32'hFF; mem_lo = 32'hEE;
        step();
        checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL hi_stored got=%0h exp=1", hi_o); end
        checks++; if (lo_o !== 32'h2) begin errors++; $display("FAIL lo_stored got=%0h exp=2", lo_o); end
    endtask

    task automatic test_back_to_back();
        mem_whilo = 1'b1; mem_hi = 32'h3; mem_lo = 32'h4;
        step();
        checks++; if (hi_o !== 32'h3 || lo_o !== 32'h4) begin errors++; $display("FAIL b2b_first got=%0h/%0h exp=3/4", hi_o, lo_o); end
        mem_hi = 32'h5; mem_lo = 32'h6;
        step();
        checks++; if (hi_o !== 32'h5 || lo_o !== 32'h6) begin errors++; $display("FAIL b2b_second got=%0h/%0h exp=5/6", hi_o, lo_o); end
        mem_whilo = 1'b0;
        step();
        checks++; if (hi_o !== 32'h5 || lo_o !== 32'h6) begin errors++; $display("FAIL b2b_stored got=%0h/%0h exp=5/6", hi_o, lo_o); end
    endtask

    task automatic test_reset_mid();
        mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'hA5A5A5A5;
        mem_whilo = 1'b1; mem_hi = 32'h77; mem_lo = 32'h88;
        step();
        checks++; if (wb_wreg !== 1'b1 || hi_o !== 32'h77) begin errors++; $display("FAIL premid wreg/hi got=%0b/%0h exp=1/77", wb_wreg, hi_o); end
        #2;
        rst = 1'b1;
        #1;
        check_zero("reset_mid");
        mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
        mem_whilo = 1'b0; mem_hi = 32'd0; mem_lo = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        step();
        check_zero("after_release");
    endtask

    initial begin
        test_reset();
        test_capture();
        test_stall();
        test_llbit();
        test_flush();
        test_hilo();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
